sb_drain_ctrl: RTL and testbench

Cache-side consumer of the store buffer. It accepts one buffered store at a time over a valid/ready handshake, looks it up in the data cache, and on a hit writes the word or byte. On a miss it evicts a dirty victim to memory, refills the line, installs it, and then performs the write. It sits between the store buffer drain port and the data cache write/fill ports plus the memory interface, and it keeps hit/miss statistics.

---
 rtl/sb_drain_ctrl_pkg.sv | 23 ++
 rtl/sb_lane_gen.sv | 26 ++
 rtl/sb_drain_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sb_drain_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_drain_ctrl_pkg.sv
// Shared types and constants for the store-buffer drain controller.
// The top and the lane generator import this package.
package sb_drain_ctrl_pkg;

    localparam int STOREBUFFER_LINE_SIZE = 16;

    localparam int SB_DATA_W     = 32;
    localparam int SB_ADDR_W     = 32;
    localparam int SB_LINE_W     = STOREBUFFER_LINE_SIZE * 8;
    localparam int SB_CNT_W      = 16;
    localparam int SB_LINE_OFF_W = $clog2(SB_LINE_W / 8);
    localparam int SB_BE_W       = SB_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVICT  = 3'd2,
        S_REFILL = 3'd3,
        S_FILL   = 3'd4,
        S_WRITE  = 3'd5
    } drain_state_t;

endpackage

// File: rtl/sb_lane_gen.sv
// Byte-enable and write-data generation for a word or byte store.
// Byte stores replicate the low byte across all lanes.
module sb_lane_gen
    import sb_drain_ctrl_pkg::*;
#(
    parameter  int DATA_W = SB_DATA_W,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              byte_st,
    input  logic [DATA_W-1:0] data_in,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] data_out
);

    always_comb begin
        be       = '1;
        data_out = data_in;
        if (byte_st) begin
            be       = BE_W'(1) << lane;
            data_out = {BE_W{data_in[7:0]}};
        end
    end

endmodule

// File: rtl/sb_drain_ctrl.sv
// Store-buffer drain controller: looks up each store, handles dirty eviction
// and line refill on a miss, then writes the word or byte into the cache.
module sb_drain_ctrl
    import sb_drain_ctrl_pkg::*;
#(
    parameter  int DATA_W = SB_DATA_W,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int LINE_W = SB_LINE_W,
    parameter  int CNT_W  = SB_CNT_W,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W),
    localparam int OFF_W  = $clog2(LINE_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_valid,
    output logic              sb_ready,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [DATA_W-1:0] sb_data,
    input  logic              sb_byte,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic              cache_hit,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_line,
    output logic              cw_en,
    output logic [ADDR_W-1:0] cw_addr,
    output logic [DATA_W-1:0] cw_data,
    output logic [BE_W-1:0]   cw_be,
    output logic              cf_en,
    output logic [ADDR_W-1:0] cf_addr,
    output logic [LINE_W-1:0] cf_line,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    drain_state_t      state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              byte_q;
    logic [ADDR_W-1:0] vaddr_q;
    logic [LINE_W-1:0] vline_q;
    logic [LINE_W-1:0] rline_q;
    logic [CNT_W-1:0]  hit_q;
    logic [CNT_W-1:0]  miss_q;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] word_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign line_addr = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign word_addr = {addr_q[ADDR_W-1:LANE_W], LANE_W'(0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            byte_q  <= 1'b0;
            vaddr_q <= '0;
            vline_q <= '0;
            rline_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (sb_valid) begin
                        addr_q <= sb_addr;
                        data_q <= sb_data;
                        byte_q <= sb_byte;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        hit_q <= sat_inc(hit_q);
                    end else begin
                        miss_q <= sat_inc(miss_q);
                        // Victim tag/data may change once the lookup is over.
                        if (victim_dirty) begin
                            vaddr_q <= victim_addr;
                            vline_q <= victim_line;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready) rline_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        sb_ready   = 1'b0;
        cw_en      = 1'b0;
        cf_en      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        mem_addr   = line_addr;
        unique case (state)
            S_IDLE: begin
                sb_ready = !rst;
                if (sb_valid) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (cache_hit)         state_next = S_WRITE;
                else if (victim_dirty) state_next = S_EVICT;
                else                   state_next = S_REFILL;
            end
            S_EVICT: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = vaddr_q;
                if (mem_ready) state_next = S_REFILL;
            end
            S_REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = S_FILL;
            end
            S_FILL: begin
                cf_en      = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                cw_en      = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    sb_lane_gen #(.DATA_W(DATA_W)) u_lane_gen (
        .lane     (addr_q[LANE_W-1:0]),
        .byte_st  (byte_q),
        .data_in  (data_q),
        .be       (cw_be),
        .data_out (cw_data)
    );

    assign lk_addr    = addr_q;
    assign cw_addr    = word_addr;
    assign cf_addr    = line_addr;
    assign cf_line    = rline_q;
    assign mem_wdata  = vline_q;
    assign busy       = (state != S_IDLE);
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_sb_drain_ctrl.sv
// Directed bench for sb_drain_ctrl: hits, clean and dirty misses, reset in
// the middle of a refill, and counter saturation with a 4-bit counter.
module tb_sb_drain_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sb_valid;
    logic              sb_ready;
    logic [ADDR_W-1:0] sb_addr;
    logic [DATA_W-1:0] sb_data;
    logic              sb_byte;
    logic [ADDR_W-1:0] lk_addr;
    logic              cache_hit;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_line;
    logic              cw_en;
    logic [ADDR_W-1:0] cw_addr;
    logic [DATA_W-1:0] cw_data;
    logic [3:0]        cw_be;
    logic              cf_en;
    logic [ADDR_W-1:0] cf_addr;
    logic [LINE_W-1:0] cf_line;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
    logic              done;
    logic              busy;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int total = 0;
    int bad   = 0;

    sb_drain_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .sb_valid(sb_valid), .sb_ready(sb_ready), .sb_addr(sb_addr),
        .sb_data(sb_data), .sb_byte(sb_byte), .lk_addr(lk_addr),
        .cache_hit(cache_hit), .victim_dirty(victim_dirty),
        .victim_addr(victim_addr), .victim_line(victim_line),
        .cw_en(cw_en), .cw_addr(cw_addr), .cw_data(cw_data), .cw_be(cw_be),
        .cf_en(cf_en), .cf_addr(cf_addr), .cf_line(cf_line),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .done(done), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One hit transaction from IDLE back to IDLE, checking the WRITE cycle.
    task automatic do_hit(input logic [31:0] a, input logic [31:0] d, input logic b,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_data, input int e_hits);
        sb_valid = 1'b1; sb_addr = a; sb_data = d; sb_byte = b; cache_hit = 1'b1;
        tick();
        sb_valid = 1'b0;
        tick();
        chk("hit_cw_en",   cw_en,     1);
        chk("hit_cw_addr", cw_addr,   e_addr);
        chk("hit_cw_be",   cw_be,     e_be);
        chk("hit_cw_data", cw_data,   e_data);
        chk("hit_count",   hit_count, e_hits);
        tick();
        chk("hit_ready_back", sb_ready, 1);
    endtask

    initial begin
        rst = 1'b1; sb_valid = 1'b0; sb_addr = '0; sb_data = '0; sb_byte = 1'b0;
        cache_hit = 1'b0; victim_dirty = 1'b0; victim_addr = '0; victim_line = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_sb_ready", sb_ready,   0);
        chk("rst_busy",     busy,       0);
        chk("rst_mem_req",  mem_req,    0);
        chk("rst_hits",     hit_count,  0);
        chk("rst_misses",   miss_count, 0);
        chk("rst_cw_en",    cw_en,      0);
        rst = 1'b0;
        #1;
        chk("idle_ready", sb_ready, 1);

        // Word hit; sb_valid held with a new address during LOOKUP is ignored.
        sb_valid = 1'b1; sb_addr = 32'h100; sb_data = 32'hDEADBEEF; sb_byte = 1'b0;
        cache_hit = 1'b1;
        tick();
        chk("wh_lookup_ready", sb_ready, 0);
        chk("wh_lookup_busy",  busy,     1);
        chk("wh_lk_addr",      lk_addr,  32'h100);
        chk("wh_lookup_cw_en", cw_en,    0);
        sb_addr = 32'h999;
        tick();
        sb_valid = 1'b0;
        chk("wh_cw_en",   cw_en,     1);
        chk("wh_done",    done,      1);
        chk("wh_cw_addr", cw_addr,   32'h100);
        chk("wh_cw_be",   cw_be,     4'b1111);
        chk("wh_cw_data", cw_data,   32'hDEADBEEF);
        chk("wh_hits",    hit_count, 1);
        tick();
        chk("wh_ready_t3", sb_ready, 1);
        chk("wh_done_off", done,     0);

        do_hit(32'h203, 32'h000000A5, 1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5, 2);

        // Clean miss, memory answers on the third REFILL cycle.
        sb_valid = 1'b1; sb_addr = 32'h1234; sb_data = 32'h12345678; sb_byte = 1'b0;
        cache_hit = 1'b0; victim_dirty = 1'b0;
        tick();
        sb_valid = 1'b0;
        tick();
        chk("cm_req",    mem_req,    1);
        chk("cm_we",     mem_we,     0);
        chk("cm_addr",   mem_addr,   32'h1230);
        chk("cm_misses", miss_count, 1);
        tick();
        chk("cm_wait_req",  mem_req,  1);
        chk("cm_wait_addr", mem_addr, 32'h1230);
        chk("cm_wait_cf",   cf_en,    0);
        tick();
        mem_ready = 1'b1; mem_rdata = {32{4'h1}};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("cm_cf_en",   cf_en,   1);
        chk("cm_cf_addr", cf_addr, 32'h1230);
        chk("cm_cf_line", cf_line, {32{4'h1}});
        chk("cm_req_off", mem_req, 0);
        tick();
        chk("cm_cw_en",   cw_en,   1);
        chk("cm_cw_addr", cw_addr, 32'h1234);
        chk("cm_cw_data", cw_data, 32'h12345678);
        tick();

        // Dirty miss, byte store to lane 0, immediate memory responses.
        sb_valid = 1'b1; sb_addr = 32'h4008; sb_data = 32'hFFFFFF3C; sb_byte = 1'b1;
        cache_hit = 1'b0; victim_dirty = 1'b1;
        victim_addr = 32'h8000; victim_line = {32{4'hA}};
        tick();
        sb_valid = 1'b0;
        tick();
        victim_addr = 32'hBAD0; victim_line = '0;
        chk("dm_ev_req",   mem_req,   1);
        chk("dm_ev_we",    mem_we,    1);
        chk("dm_ev_addr",  mem_addr,  32'h8000);
        chk("dm_ev_wdata", mem_wdata, {32{4'hA}});
        mem_ready = 1'b1; mem_rdata = {32{4'h5}};
        tick();
        chk("dm_rf_req",  mem_req,  1);
        chk("dm_rf_we",   mem_we,   0);
        chk("dm_rf_addr", mem_addr, 32'h4000);
        tick();
        mem_ready = 1'b0;
        chk("dm_cf_en",   cf_en,   1);
        chk("dm_cf_addr", cf_addr, 32'h4000);
        chk("dm_cf_line", cf_line, {32{4'h5}});
        tick();
        chk("dm_cw_en",   cw_en,      1);
        chk("dm_cw_addr", cw_addr,    32'h4008);
        chk("dm_cw_be",   cw_be,      4'b0001);
        chk("dm_cw_data", cw_data,    32'h3C3C3C3C);
        chk("dm_misses",  miss_count, 2);
        tick();

        // Reset while REFILL is waiting on memory.
        sb_valid = 1'b1; sb_addr = 32'h300; sb_data = 32'h1; sb_byte = 1'b0;
        cache_hit = 1'b0; victim_dirty = 1'b0;
        tick();
        sb_valid = 1'b0;
        tick();
        chk("rr_req_before", mem_req, 1);
        rst = 1'b1;
        tick();
        chk("rr_req",     mem_req,    0);
        chk("rr_busy",    busy,       0);
        chk("rr_hits",    hit_count,  0);
        chk("rr_misses",  miss_count, 0);
        chk("rr_ready",   sb_ready,   0);
        chk("rr_lk_addr", lk_addr,    0);
        rst = 1'b0;
        #1;
        chk("rr_ready_after", sb_ready, 1);

        // Saturation of the 4-bit hit counter over 18 hits.
        for (int i = 0; i < 18; i++) begin
            do_hit(32'h40 + 32'(i), 32'h11 * 32'(i), 1'b1, 32'h40 + 32'(i & ~3),
                   4'b0001 << (i % 4), {4{8'(8'h11 * i)}}, (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_hits",   hit_count,  4'hF);
        chk("sat_misses", miss_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
